transform_scan_ctrl: RTL and testbench

//  Frame sequencer for the transformation pipeline (shifter->rotator->zoomer->toScreen).
//  On START it snapshots center/zoom/angle and raster-scans source coords (0,0)..(W-1,H-1).

---
 rtl/transform_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_transform_scan_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transform_scan_ctrl.sv
// transform_scan_ctrl: frame sequencer that raster-scans source coordinates through the
// transform pipeline and gates its write strobe. Optional build macro: TSC_BACKPRESSURE_EN.
module transform_scan_ctrl #(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int PIPE_LAT = 4
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic       START,
    input  logic       ABORT,
    input  logic [7:0] XcenterIn,
    input  logic [7:0] YcenterIn,
    input  logic [7:0] ZoomIn,
    input  logic [7:0] AngleIn,
    input  logic       PipeWrite,
`ifdef TSC_BACKPRESSURE_EN
    input  logic       WR_READY,
`endif
    output logic       ENB,
    output logic [7:0] Xcoord,
    output logic [7:0] Ycoord,
    output logic [7:0] Xcenter,
    output logic [7:0] Ycenter,
    output logic [7:0] Zoom,
    output logic [7:0] Angle,
    output logic       WR_EN,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] X_LAST = 8'(IMG_W - 1);
    localparam logic [7:0] Y_LAST = 8'(IMG_H - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_x;
    logic [7:0]          r_y;
    logic [7:0]          r_xc;
    logic [7:0]          r_yc;
    logic [7:0]          r_zoom;
    logic [7:0]          r_angle;
    logic [PIPE_LAT-1:0] r_tag;

    logic w_ready;
    logic w_enb;
    logic w_tag_in;
    logic w_load_cfg;
    logic w_advance;
    logic w_last_x;
    logic w_last_pix;

`ifdef TSC_BACKPRESSURE_EN
    assign w_ready = WR_READY;
`else
    assign w_ready = 1'b1;
`endif

    assign w_last_x   = (r_x == X_LAST);
    assign w_last_pix = w_last_x && (r_y == Y_LAST);

    // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_enb       = 1'b0;
        w_tag_in    = 1'b0;
        w_load_cfg  = 1'b0;
        w_advance   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = S_LOAD;
                    w_load_cfg  = 1'b1;
                end
            end
            S_LOAD: begin
                w_state_nxt = ABORT ? S_DRAIN : S_SCAN;
            end
            S_SCAN: begin
                w_enb    = w_ready;
                w_tag_in = 1'b1;
                // An aborted cycle still issues its coordinate; the counters just stop there.
                if (ABORT || (w_ready && w_last_pix)) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_advance = w_ready;
                end
            end
            S_DRAIN: begin
                w_enb = w_ready;
                if (w_ready && (r_tag == '0)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_load_cfg) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_advance) begin
            if (w_last_x) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? '0 : r_y + 8'd1;
            end else begin
                r_x <= r_x + 8'd1;
            end
        end
    end

    // Tag pipe mirrors the pipeline depth; bit PIPE_LAT-1 marks a real pixel at the output.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_tag <= '0;
        end else if (w_enb) begin
            r_tag <= (r_tag << 1) | PIPE_LAT'(w_tag_in);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_xc    <= '0;
            r_yc    <= '0;
            r_zoom  <= '0;
            r_angle <= '0;
        end else if (w_load_cfg) begin
            r_xc    <= XcenterIn;
            r_yc    <= YcenterIn;
            r_zoom  <= ZoomIn;
            r_angle <= AngleIn;
        end
    end

    assign ENB     = w_enb;
    assign Xcoord  = r_x;
    assign Ycoord  = r_y;
    assign Xcenter = r_xc;
    assign Ycenter = r_yc;
    assign Zoom    = r_zoom;
    assign Angle   = r_angle;
    assign WR_EN   = PipeWrite & r_tag[PIPE_LAT-1] & w_ready;
    assign BUSY    = (r_state != S_IDLE);
    assign DONE    = (r_state == S_DONE);

endmodule

// File: tb/tb_transform_scan_ctrl.sv
// Self-checking bench for transform_scan_ctrl (4x2 image, 4-stage pipeline model).
// Define TSC_BACKPRESSURE_EN to also exercise the WR_READY stall path.
module tb_transform_scan_ctrl;

    localparam int W      = 4;
    localparam int H      = 2;
    localparam int L      = 4;
    localparam int NPIX   = W * H;
    localparam int BUDGET = 60;

    logic       ACLK = 1'b0;
    logic       ARESETn;
    logic       START;
    logic       ABORT;
    logic [7:0] XcenterIn, YcenterIn, ZoomIn, AngleIn;
    logic       PipeWrite;
    logic       WR_READY;
    logic       ENB;
    logic [7:0] Xcoord, Ycoord, Xcenter, Ycenter, Zoom, Angle;
    logic       WR_EN, BUSY, DONE;

    int n_checks = 0;
    int n_pass   = 0;
    int done_total = 0;
    int wr_total   = 0;

    logic [15:0] q[$];

    logic       p_v [L];
    logic [7:0] p_x [L];
    logic [7:0] p_y [L];

    always #5 ACLK = ~ACLK;

    transform_scan_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(L)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .START     (START),
        .ABORT     (ABORT),
        .XcenterIn (XcenterIn),
        .YcenterIn (YcenterIn),
        .ZoomIn    (ZoomIn),
        .AngleIn   (AngleIn),
        .PipeWrite (PipeWrite),
`ifdef TSC_BACKPRESSURE_EN
        .WR_READY  (WR_READY),
`endif
        .ENB       (ENB),
        .Xcoord    (Xcoord),
        .Ycoord    (Ycoord),
        .Xcenter   (Xcenter),
        .Ycenter   (Ycenter),
        .Zoom      (Zoom),
        .Angle     (Angle),
        .WR_EN     (WR_EN),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    // Pipeline model: L-deep shift of (valid, x, y) advancing only on ENB.
    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < L; i++) begin
                p_v[i] <= 1'b0;
                p_x[i] <= '0;
                p_y[i] <= '0;
            end
        end else if (ENB) begin
            p_v[0] <= 1'b1;
            p_x[0] <= Xcoord;
            p_y[0] <= Ycoord;
            for (int i = 1; i < L; i++) begin
                p_v[i] <= p_v[i-1];
                p_x[i] <= p_x[i-1];
                p_y[i] <= p_y[i-1];
            end
        end
    end

    assign PipeWrite = p_v[L-1];

    // Scoreboard consumer: every WR_EN must retire the next expected pixel.
    always @(negedge ACLK) begin
        if (ARESETn === 1'b1) begin
            if (DONE === 1'b1) done_total++;
            if (WR_EN === 1'b1) begin
                wr_total++;
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL wr_leak: WR_EN with pixel (%0d,%0d) but no pixel expected",
                             p_x[L-1], p_y[L-1]);
                end else begin
                    logic [15:0] e;
                    e = q.pop_front();
                    if ({p_x[L-1], p_y[L-1]} !== e)
                        $display("FAIL wr_pixel: got (%0d,%0d) expected (%0d,%0d)",
                                 p_x[L-1], p_y[L-1], e[15:8], e[7:0]);
                    else
                        n_pass++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_pixels(input int n);
        for (int i = 0; i < n; i++) q.push_back({8'(i % W), 8'(i / W)});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    // Runs one frame; edge k is the k-th rising edge after E0 (the edge that samples START).
    // Returns at the negedge inside the DONE cycle, or after BUDGET edges.
    task automatic do_frame(input logic [7:0] xc, input logic [7:0] yc,
                            input logic [7:0] zm, input logic [7:0] an,
                            input int abort_k, input int stall_k, input int stall_n,
                            input int mid_k, input logic abort_with_start,
                            output int done_k, output int enb_first,
                            output int wr_n, output bit stall_ok);
        logic [7:0] fx, fy;
        fx = '0;
        fy = '0;
        push_pixels((abort_k > 0) ? abort_k : NPIX);
        done_k    = -1;
        enb_first = -1;
        wr_n      = 0;
        stall_ok  = 1'b1;
        @(negedge ACLK);
        XcenterIn = xc; YcenterIn = yc; ZoomIn = zm; AngleIn = an;
        START = 1'b1;
        ABORT = abort_with_start;
        @(posedge ACLK);
        @(negedge ACLK);
        START = 1'b0;
        ABORT = 1'b0;
        for (int k = 1; k <= BUDGET && done_k < 0; k++) begin
            @(posedge ACLK);
            @(negedge ACLK);
            if (ENB === 1'b1 && enb_first < 0) enb_first = k;
            if (WR_EN === 1'b1) wr_n++;
            if (DONE === 1'b1) done_k = k;
            if (k == stall_k) begin
                fx = Xcoord;
                fy = Ycoord;
            end
            if (stall_n > 0 && k > stall_k && k <= stall_k + stall_n)
                if (ENB !== 1'b0 || Xcoord !== fx || Ycoord !== fy) stall_ok = 1'b0;
            ABORT = (k == abort_k);
            WR_READY = (stall_n == 0) || !(k >= stall_k && k < stall_k + stall_n);
            if (k == mid_k) begin
                START = 1'b1;
                XcenterIn = ~xc; YcenterIn = ~yc; ZoomIn = ~zm; AngleIn = ~an;
            end else begin
                START = 1'b0;
            end
        end
        START = 1'b0;
        ABORT = 1'b0;
        WR_READY = 1'b1;
    endtask

    task automatic test_reset;
        int done_k, enb_first, wr_n;
        bit stall_ok, found;
        ARESETn = 1'b0;
        START = 1'b0; ABORT = 1'b0; WR_READY = 1'b1;
        XcenterIn = '0; YcenterIn = '0; ZoomIn = '0; AngleIn = '0;
        #12;
        n_checks++;
        if ({ENB, Xcoord, Ycoord, Xcenter, Ycenter, Zoom, Angle, WR_EN, BUSY, DONE} !== '0)
            $display("FAIL reset_initial: outputs %h expected all zero",
                     {ENB, Xcoord, Ycoord, Xcenter, Ycenter, Zoom, Angle, WR_EN, BUSY, DONE});
        else n_pass++;
        @(negedge ACLK);
        ARESETn = 1'b1;
        push_pixels(NPIX);
        @(negedge ACLK);
        XcenterIn = 8'h11; YcenterIn = 8'h22; ZoomIn = 8'h33; AngleIn = 8'h44;
        START = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        START = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge ACLK);
            @(negedge ACLK);
            if (ENB === 1'b1 && Xcoord == 8'd2 && Ycoord == 8'd1) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL reset_reach_2_1: coordinate (2,1) not seen within 40 cycles");
        else n_pass++;
        #2 ARESETn = 1'b0;
        #1;
        n_checks++;
        if ({ENB, Xcoord, Ycoord, WR_EN, BUSY, DONE} !== '0)
            $display("FAIL reset_mid_scan_ctrl: ENB/X/Y/WR_EN/BUSY/DONE %h expected 0",
                     {ENB, Xcoord, Ycoord, WR_EN, BUSY, DONE});
        else n_pass++;
        n_checks++;
        if ({Xcenter, Ycenter, Zoom, Angle} !== 32'h0)
            $display("FAIL reset_mid_scan_cfg: shadow %h expected 0", {Xcenter, Ycenter, Zoom, Angle});
        else n_pass++;
        q.delete();
        @(negedge ACLK);
        ARESETn = 1'b1;
        do_frame(8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 0, 0, 1'b0, done_k, enb_first, wr_n, stall_ok);
        n_checks++;
        if (done_k !== 14 || wr_n !== NPIX)
            $display("FAIL reset_refresh_frame: done edge %0d wr %0d expected 14 and %0d", done_k, wr_n, NPIX);
        else n_pass++;
    endtask

    task automatic test_frame;
        int done_k, enb_first, wr_n;
        bit stall_ok;
        do_frame(8'h10, 8'h20, 8'h80, 8'h40, 0, 0, 0, 0, 1'b0, done_k, enb_first, wr_n, stall_ok);
        n_checks++;
        if (done_k !== 14) $display("FAIL frame_done_edge: got E0+%0d expected E0+14", done_k);
        else n_pass++;
        n_checks++;
        if (enb_first !== 1) $display("FAIL frame_enb_first: got E0+%0d expected E0+1", enb_first);
        else n_pass++;
        n_checks++;
        if (wr_n !== NPIX) $display("FAIL frame_wr_count: got %0d expected %0d", wr_n, NPIX);
        else n_pass++;
        n_checks++;
        if ({Xcenter, Ycenter, Zoom, Angle} !== 32'h10208040)
            $display("FAIL frame_shadow_cfg: got %h expected 10208040", {Xcenter, Ycenter, Zoom, Angle});
        else n_pass++;
        n_checks++;
        if (BUSY !== 1'b1 || ENB !== 1'b0)
            $display("FAIL frame_done_cycle: BUSY %b ENB %b expected 1 and 0", BUSY, ENB);
        else n_pass++;
        @(negedge ACLK);
        n_checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || ENB !== 1'b0)
            $display("FAIL frame_idle_after: BUSY %b DONE %b ENB %b expected 0 0 0", BUSY, DONE, ENB);
        else n_pass++;
    endtask

    task automatic test_midframe_ignore;
        int done_k, enb_first, wr_n, d0;
        bit stall_ok;
        d0 = done_total;
        do_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3, 0, 0, 0, 4, 1'b0, done_k, enb_first, wr_n, stall_ok);
        idle(6);
        n_checks++;
        if ({Xcenter, Ycenter, Zoom, Angle} !== 32'h5AA53CC3)
            $display("FAIL mid_shadow_cfg: got %h expected 5aa53cc3", {Xcenter, Ycenter, Zoom, Angle});
        else n_pass++;
        n_checks++;
        if (done_k !== 14 || wr_n !== NPIX)
            $display("FAIL mid_sequence: done edge %0d wr %0d expected 14 and %0d", done_k, wr_n, NPIX);
        else n_pass++;
        n_checks++;
        if (done_total - d0 !== 1) $display("FAIL mid_done_count: got %0d expected 1", done_total - d0);
        else n_pass++;
    endtask

    task automatic test_abort;
        int done_k, enb_first, wr_n;
        bit stall_ok;
        // ABORT sampled at E4 (third SCAN cycle) -> DRAIN from E4, tag empty at E8, DONE at E9.
        do_frame(8'h01, 8'h01, 8'h01, 8'h01, 3, 0, 0, 0, 1'b0, done_k, enb_first, wr_n, stall_ok);
        n_checks++;
        if (wr_n !== 3) $display("FAIL abort_wr_count: got %0d expected 3", wr_n);
        else n_pass++;
        n_checks++;
        if (done_k !== 9) $display("FAIL abort_done_edge: got E0+%0d expected E0+9", done_k);
        else n_pass++;
        idle(3);
        n_checks++;
        if (q.size() !== 0) $display("FAIL abort_queue_empty: %0d pixels outstanding expected 0", q.size());
        else n_pass++;
    endtask

    task automatic test_start_abort_idle;
        int done_k, enb_first, wr_n;
        bit stall_ok;
        do_frame(8'h07, 8'h08, 8'h09, 8'h0A, 0, 0, 0, 0, 1'b1, done_k, enb_first, wr_n, stall_ok);
        n_checks++;
        if (done_k !== 14 || wr_n !== NPIX)
            $display("FAIL start_abort_idle: done edge %0d wr %0d expected 14 and %0d", done_k, wr_n, NPIX);
        else n_pass++;
        idle(2);
    endtask

`ifdef TSC_BACKPRESSURE_EN
    task automatic test_backpressure;
        int done_k, enb_first, wr_n;
        bit stall_ok;
        do_frame(8'h21, 8'h22, 8'h23, 8'h24, 0, 3, 3, 0, 1'b0, done_k, enb_first, wr_n, stall_ok);
        n_checks++;
        if (stall_ok !== 1'b1) $display("FAIL bp_frozen: ENB/coords moved during stall (ok=%b expected 1)", stall_ok);
        else n_pass++;
        n_checks++;
        if (wr_n !== NPIX) $display("FAIL bp_wr_count: got %0d expected %0d", wr_n, NPIX);
        else n_pass++;
        n_checks++;
        if (done_k !== 17) $display("FAIL bp_done_edge: got E0+%0d expected E0+17", done_k);
        else n_pass++;
        idle(2);
    endtask
`endif

    task automatic test_back_to_back;
        int done_a, done_b, enb_a, enb_b, wr_a, wr_b, w0;
        bit stall_ok;
        w0 = wr_total;
        do_frame(8'h31, 8'h32, 8'h33, 8'h34, 0, 0, 0, 0, 1'b0, done_a, enb_a, wr_a, stall_ok);
        do_frame(8'h31, 8'h32, 8'h33, 8'h34, 0, 0, 0, 0, 1'b0, done_b, enb_b, wr_b, stall_ok);
        idle(6);
        n_checks++;
        if (done_a !== 14 || done_b !== 14)
            $display("FAIL b2b_done_edges: got %0d and %0d expected 14 and 14", done_a, done_b);
        else n_pass++;
        n_checks++;
        if (wr_a !== NPIX || wr_b !== NPIX || enb_b !== 1)
            $display("FAIL b2b_second_frame: wr %0d/%0d enb_first %0d expected %0d/%0d and 1",
                     wr_a, wr_b, enb_b, NPIX, NPIX);
        else n_pass++;
        n_checks++;
        if (wr_total - w0 !== 2 * NPIX || q.size() !== 0)
            $display("FAIL b2b_no_leak: wr %0d outstanding %0d expected %0d and 0",
                     wr_total - w0, q.size(), 2 * NPIX);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_midframe_ignore();
        test_abort();
        test_start_abort_idle();
`ifdef TSC_BACKPRESSURE_EN
        test_backpressure();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
